// File: rtl/rfile_pkg.sv
// Shared widths, LUT fetch state encoding and result record for the RF localisation host.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rfile_pkg;

  localparam int COORD_W = 8;
  localparam int RSSI_W  = 20;
  localparam int EXP_W   = 12;
  localparam int VAL_W   = 16;

  // 10^frac table walk: one address per state, data lands one state later.
  typedef enum logic [1:0] {
    LUT_IDLE,
    LUT_RA,
    LUT_RB,
    LUT_RC
  } lut_state_t;

  // One engine result as stored in the result FIFO.
  typedef struct packed {
    logic [COORD_W-1:0] xt;
    logic [COORD_W-1:0] yt;
  } res_t;

endpackage

// File: rtl/rfile_result_fifo.sv
// Generic synchronous FIFO holding engine results.
// Latency: push visible at head on the next cycle; head is read combinationally from storage.
// Backpressure: none internally; the caller must never push when full (credit-gated upstream).
// Ports: clk/rst, push + push_dat, pop, head_dat, empty, count (0..DEPTH).
module rfile_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Upstream credit accounting guarantees room; a hit here is a flow-control bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/rfile_host.sv
// Host initiator for the RF localisation engine: commits RSSI per frame, fetches 10^frac mantissas, collects results.
// Latency: sample registered at the commit edge; result enters FIFO on out_valid; mantissas settle within 5 cycles of an exp change.
// Backpressure: s_ready only in a commit window with FIFO credit; results of frames without a fresh sample are dropped as dummies.
// Ports: cfg_* anchors (passed through to A_x..C_y), s_* sample stream, rssi*/value* to engine,
//        exp*/busy/out_valid/xt/yt from engine, lut_addr/lut_rdata ROM port, m_* result stream, frame counters.
module rfile_host
  import rfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] cfg_ax,
  input  logic [COORD_W-1:0] cfg_ay,
  input  logic [COORD_W-1:0] cfg_bx,
  input  logic [COORD_W-1:0] cfg_by,
  input  logic [COORD_W-1:0] cfg_cx,
  input  logic [COORD_W-1:0] cfg_cy,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [RSSI_W-1:0]  s_rssiA,
  input  logic [RSSI_W-1:0]  s_rssiB,
  input  logic [RSSI_W-1:0]  s_rssiC,
  output logic [COORD_W-1:0] A_x,
  output logic [COORD_W-1:0] A_y,
  output logic [COORD_W-1:0] B_x,
  output logic [COORD_W-1:0] B_y,
  output logic [COORD_W-1:0] C_x,
  output logic [COORD_W-1:0] C_y,
  output logic [RSSI_W-1:0]  rssiA,
  output logic [RSSI_W-1:0]  rssiB,
  output logic [RSSI_W-1:0]  rssiC,
  output logic [VAL_W-1:0]   valueA,
  output logic [VAL_W-1:0]   valueB,
  output logic [VAL_W-1:0]   valueC,
  input  logic [EXP_W-1:0]   expA,
  input  logic [EXP_W-1:0]   expB,
  input  logic [EXP_W-1:0]   expC,
  input  logic               busy,
  input  logic               out_valid,
  input  logic [COORD_W-1:0] xt,
  input  logic [COORD_W-1:0] yt,
  output logic [EXP_W-1:0]   lut_addr,
  input  logic [VAL_W-1:0]   lut_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COORD_W-1:0] m_xt,
  output logic [COORD_W-1:0] m_yt,
  output logic [CNT_W-1:0]   frames_done,
  output logic [CNT_W-1:0]   frames_dummy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic          inflight_real;
  logic          push_now;
  logic          credit;
  logic          xfer;
  logic          pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  res_t          push_res;
  res_t          head_res;

  lut_state_t       lut_state;
  logic [EXP_W-1:0] sh_a, sh_b, sh_c;
  logic             c_pend;

  assign A_x = cfg_ax;
  assign A_y = cfg_ay;
  assign B_x = cfg_bx;
  assign B_y = cfg_by;
  assign C_x = cfg_cx;
  assign C_y = cfg_cy;

  // Only results of frames that carried a fresh sample are kept.
  assign push_now = out_valid && inflight_real;

  // Same-cycle pop is deliberately not credited: simpler and never overflows.
  assign credit  = ({1'b0, fifo_count} + {{CW{1'b0}}, push_now}) < DEPTH_L;
  // rst term keeps s_ready low while held in reset even though busy may be low.
  assign s_ready = !rst && !busy && credit;
  assign xfer    = s_valid && s_ready;

  assign pop      = m_valid && m_ready;
  assign push_res = '{xt: xt, yt: yt};
  assign m_valid  = !fifo_empty;
  assign m_xt     = head_res.xt;
  assign m_yt     = head_res.yt;

  rfile_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(res_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_now),
    .push_dat (push_res),
    .pop      (pop),
    .head_dat (head_res),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // RSSI commit: the engine samples rssi* in the window, so they only move at
  // the edge closing a window and stay put for the whole busy interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rssiA         <= '0;
      rssiB         <= '0;
      rssiC         <= '0;
      inflight_real <= 1'b0;
    end else if (xfer) begin
      rssiA         <= s_rssiA;
      rssiB         <= s_rssiB;
      rssiC         <= s_rssiC;
      inflight_real <= 1'b1;
    end else if (!busy) begin
      // Engine will recompute the stale sample; mark that frame as dummy.
      inflight_real <= 1'b0;
    end
  end

  // Frame statistics; inflight_real here is the pre-commit value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_done  <= '0;
      frames_dummy <= '0;
    end else if (out_valid) begin
      if (inflight_real) begin
        if (frames_done != '1) frames_done <= frames_done + 1'b1;
      end else begin
        if (frames_dummy != '1) frames_dummy <= frames_dummy + 1'b1;
      end
    end
  end

  // Mantissa fetch. ROM data lags the address by one cycle, so each value is
  // captured one state after its address was issued; valueC lands back in IDLE.
  // Shadows reset to all-ones so the first real exponents trigger a fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_state <= LUT_IDLE;
      lut_addr  <= '0;
      sh_a      <= '1;
      sh_b      <= '1;
      sh_c      <= '1;
      valueA    <= '0;
      valueB    <= '0;
      valueC    <= '0;
      c_pend    <= 1'b0;
    end else begin
      case (lut_state)
        LUT_IDLE: begin
          if (c_pend) begin
            valueC <= lut_rdata;
            c_pend <= 1'b0;
          end
          // Also catches exponents that moved while the previous walk ran.
          if ({expA, expB, expC} != {sh_a, sh_b, sh_c}) begin
            sh_a      <= expA;
            sh_b      <= expB;
            sh_c      <= expC;
            lut_addr  <= expA;
            lut_state <= LUT_RA;
          end
        end
        LUT_RA: begin
          lut_addr  <= sh_b;
          lut_state <= LUT_RB;
        end
        LUT_RB: begin
          valueA    <= lut_rdata;
          lut_addr  <= sh_c;
          lut_state <= LUT_RC;
        end
        LUT_RC: begin
          valueB    <= lut_rdata;
          c_pend    <= 1'b1;
          lut_state <= LUT_IDLE;
        end
        default: lut_state <= LUT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfile_host.sv
// Directed bench for rfile_host: engine BFM with a 4-cycle frame (one commit window then three busy cycles),
// a 1-cycle synchronous ROM model, and hand-computed expectations checked at negative clock edges.
// Inputs are driven at negedge (or 1 time unit after posedge for the BFMs).
module tb_rfile_host;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_ax, cfg_ay, cfg_bx, cfg_by, cfg_cx, cfg_cy;
  logic        s_valid, s_ready;
  logic [19:0] s_rssiA, s_rssiB, s_rssiC;
  logic [7:0]  A_x, A_y, B_x, B_y, C_x, C_y;
  logic [19:0] rssiA, rssiB, rssiC;
  logic [15:0] valueA, valueB, valueC;
  logic [11:0] expA, expB, expC;
  logic        busy, out_valid;
  logic [7:0]  xt, yt;
  logic [11:0] lut_addr;
  logic [15:0] lut_rdata;
  logic        m_valid, m_ready;
  logic [7:0]  m_xt, m_yt;
  logic [15:0] frames_done, frames_dummy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int eng_ph;
  int eng_n;
  logic [11:0] rom_a;

  rfile_host #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_ax(cfg_ax), .cfg_ay(cfg_ay), .cfg_bx(cfg_bx), .cfg_by(cfg_by), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy),
    .s_valid(s_valid), .s_ready(s_ready), .s_rssiA(s_rssiA), .s_rssiB(s_rssiB), .s_rssiC(s_rssiC),
    .A_x(A_x), .A_y(A_y), .B_x(B_x), .B_y(B_y), .C_x(C_x), .C_y(C_y),
    .rssiA(rssiA), .rssiB(rssiB), .rssiC(rssiC),
    .valueA(valueA), .valueB(valueB), .valueC(valueC),
    .expA(expA), .expB(expB), .expC(expC),
    .busy(busy), .out_valid(out_valid), .xt(xt), .yt(yt),
    .lut_addr(lut_addr), .lut_rdata(lut_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_xt(m_xt), .m_yt(m_yt),
    .frames_done(frames_done), .frames_dummy(frames_dummy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index since reset release: negedge after the k-th active edge sees cyc==k.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // 10^frac table stand-in: distinct, easy to hand-compute.
  function automatic logic [15:0] rom(input logic [11:0] a);
    return 16'h5000 | {4'h0, a};
  endfunction

  // Synchronous ROM, one cycle read latency.
  initial begin
    lut_rdata = '0;
    forever begin
      @(negedge clk);
      rom_a = lut_addr;
      @(posedge clk);
      #1 lut_rdata = rom(rom_a);
    end
  end

  // Engine BFM: window at phase 0, busy for phases 1..3. Every window but the
  // first after reset carries out_valid with result n = (30+2n, 40+2n).
  initial begin
    busy = 1'b0; out_valid = 1'b0; xt = '0; yt = '0; eng_ph = 0; eng_n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        eng_ph = 0; eng_n = 0; busy = 1'b0; out_valid = 1'b0;
      end else begin
        eng_ph = (eng_ph + 1) % 4;
        if (eng_ph == 0) begin
          busy = 1'b0; out_valid = 1'b1;
          xt = 8'(30 + 2 * eng_n);
          yt = 8'(40 + 2 * eng_n);
          eng_n++;
        end else begin
          busy = 1'b1; out_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic to_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b0; s_valid = 1'b0;
    s_rssiA = '0; s_rssiB = '0; s_rssiC = '0;
    cfg_ax = 8'd0; cfg_ay = 8'd0; cfg_bx = 8'd100; cfg_by = 8'd0; cfg_cx = 8'd0; cfg_cy = 8'd100;
    expA = 12'h001; expB = 12'h002; expC = 12'h003;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rssiA", rssiA, 0);
    chk("rst_valueA", valueA, 0);
    chk("rst_lut_addr", lut_addr, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_frames_dummy", frames_dummy, 0);
    chk("anchor_bx", B_x, 100);
    chk("anchor_cy", C_y, 100);

    // One real sample, then dummy frames
    s_rssiA = 20'h01000; s_rssiB = 20'h02000; s_rssiC = 20'h03000; s_valid = 1'b1;
    rst = 1'b0;
    #1 chk("win0_s_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t1_rssiA", rssiA, 20'h01000);
    chk("t1_rssiC", rssiC, 20'h03000);
    chk("t1_lut_addr_first", lut_addr, 12'h001);
    to_cyc(5);
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_xt", m_xt, 30);
    chk("t1_m_yt", m_yt, 40);
    chk("t1_frames_done", frames_done, 1);
    chk("t1_frames_dummy", frames_dummy, 0);
    chk("t1_valueA", valueA, rom(12'h001));
    chk("t1_valueB", valueB, rom(12'h002));
    chk("t1_valueC", valueC, rom(12'h003));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t1_popped", m_valid, 0);
    to_cyc(17);
    chk("t2_frames_dummy", frames_dummy, 3);
    chk("t2_frames_done", frames_done, 1);
    chk("t2_m_valid", m_valid, 0);
    chk("t2_rssi_hold", rssiA, 20'h01000);

    // Backpressure with FIFO_DEPTH=2 and m_ready low
    s_rssiA = 20'h00010; s_rssiB = 20'h00020; s_rssiC = 20'h00030; s_valid = 1'b1;
    do_reset();
    to_cyc(1);  s_rssiA = 20'h00011;
    to_cyc(4);  chk("bp_s_ready4", s_ready, 1);
    to_cyc(5);  s_rssiA = 20'h00012;
    to_cyc(8);  chk("bp_s_ready8", s_ready, 0);
    to_cyc(12); chk("bp_s_ready12", s_ready, 0);
    to_cyc(13);
    chk("bp_frames_done", frames_done, 2);
    chk("bp_frames_dummy", frames_dummy, 1);
    chk("bp_rssiA_hold", rssiA, 20'h00011);
    chk("bp_head0_xt", m_xt, 30);
    m_ready = 1'b1;
    to_cyc(14); chk("bp_head1_xt", m_xt, 32); chk("bp_head1_yt", m_yt, 42);
    to_cyc(15); chk("bp_drained", m_valid, 0); m_ready = 1'b0;
    to_cyc(16); chk("bp_resume", s_ready, 1);
    to_cyc(17); chk("bp_rssiA_new", rssiA, 20'h00012); s_rssiA = 20'h00013;
    to_cyc(21); s_valid = 1'b0;

    // Push and pop in the same cycle with one entry held
    to_cyc(24);
    chk("pp_head_xt", m_xt, 38);
    chk("pp_s_ready", s_ready, 0);
    m_ready = 1'b1;
    to_cyc(25);
    chk("pp_m_valid", m_valid, 1);
    chk("pp_m_xt", m_xt, 40);
    chk("pp_m_yt", m_yt, 50);
    chk("pp_frames_done", frames_done, 4);
    to_cyc(26);
    chk("pp_count_was_1", m_valid, 0);

    // LUT fetch sequence
    expA = 12'h000; expB = 12'h800; expC = 12'hFFF;
    to_cyc(27); chk("lut_addr_a", lut_addr, 12'h000);
    to_cyc(28); chk("lut_addr_b", lut_addr, 12'h800);
    to_cyc(29); chk("lut_addr_c", lut_addr, 12'hFFF);
    to_cyc(31);
    chk("lut_valueA", valueA, rom(12'h000));
    chk("lut_valueB", valueB, rom(12'h800));
    chk("lut_valueC", valueC, rom(12'hFFF));

    // Exponent change in the middle of a walk
    to_cyc(33); expA = 12'h0AA; expB = 12'h0BB; expC = 12'h0CC;
    to_cyc(35); expA = 12'h111; expB = 12'h222; expC = 12'h333;
    to_cyc(37); chk("mid_valueA", valueA, rom(12'h0AA));
    to_cyc(38);
    chk("mid_refetch_addr", lut_addr, 12'h111);
    chk("mid_valueC", valueC, rom(12'h0CC));
    to_cyc(42);
    chk("mid_valueA2", valueA, rom(12'h111));
    chk("mid_valueB2", valueB, rom(12'h222));
    chk("mid_valueC2", valueC, rom(12'h333));

    // Reset asserted in the middle of a busy interval
    to_cyc(44); s_rssiA = 20'h00014; s_valid = 1'b1;
    to_cyc(45); chk("mr_rssiA_pre", rssiA, 20'h00014); s_rssiA = 20'h00015; m_ready = 1'b0;
    to_cyc(46);
    rst = 1'b1;
    #1;
    chk("mr_s_ready", s_ready, 0);
    chk("mr_rssiA", rssiA, 0);
    chk("mr_valueA", valueA, 0);
    chk("mr_lut_addr", lut_addr, 0);
    chk("mr_frames_done", frames_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    chk("mr_rssiA_first", rssiA, 20'h00015);
    to_cyc(5);
    chk("mr_m_valid", m_valid, 1);
    chk("mr_m_xt", m_xt, 30);
    chk("mr_frames_done_new", frames_done, 1);
    chk("mr_valueA_refetch", valueA, rom(12'h111));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rfile_host.md
Name: rfile_host

Overview:
- Host-side initiator for the RF indoor localization engine.
- Drives the fixed anchor coordinates, a committed RSSI triple per frame, and the 10^frac mantissa values (valueA/B/C) the engine needs.
- Captures xt/yt on out_valid into a small result FIFO.
- The engine never stalls and recomputes every frame, so this block tags each in-flight frame as real or dummy, discards dummy results, and applies credit-based flow control on the sample stream.

Parameters:
- FIFO_DEPTH, 2: result FIFO entries (power of 2, >=2).
- CNT_W, 16: width of the frame statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_ax, cfg_ay, cfg_bx, cfg_by, cfg_cx, cfg_cy  in  8 each  anchor coordinates; must be stable from reset release.
- s_valid  in  1  RSSI sample valid.
- s_ready  out  1  sample accepted this cycle.
- s_rssiA, s_rssiB, s_rssiC  in  20 each  RSSI samples (fixed 8.12).
- A_x, A_y, B_x, B_y, C_x, C_y  out  8 each  to engine; combinational copy of the cfg_* inputs.
- rssiA, rssiB, rssiC  out  20 each  to engine, registered.
- valueA, valueB, valueC  out  16 each  to engine, registered mantissas.
- expA, expB, expC  in  12 each  from engine, fractional exponent.
- busy  in  1  from engine.
- out_valid  in  1  from engine.
- xt, yt  in  8 each  from engine.
- lut_addr  out  12  synchronous ROM address (10^frac table).
- lut_rdata  in  16  ROM data, 1-cycle read latency.
- m_valid  out  1  result FIFO not empty.
- m_ready  in  1  consumer pops.
- m_xt, m_yt  out  8 each  FIFO head.
- frames_done, frames_dummy  out  CNT_W each  saturating counters.

Behaviour:
- Reset values:
  - rssi*, value*, lut_addr: 0.
  - s_ready, m_valid: 0.
  - FIFO empty.
  - Counters: 0.
  - inflight_real: 0.
  - LUT FSM: IDLE.
  - Exp shadow registers: 0xFFF, which forces a fetch after reset.
- Commit window: a cycle with busy==0.
  - Engine out_valid coincides with the second and later windows.
  - The first window after reset has no out_valid.
- s_ready is combinational: (busy==0) && credit.
  - credit = (fifo_count + push_now) < FIFO_DEPTH.
  - push_now = out_valid && inflight_real.
  - Pop in the same cycle is ignored for credit (conservative).
- Transfer on s_valid && s_ready:
  - rssi* <= s_rssi* at the next edge.
  - inflight_real <= 1.
- Commit window without a transfer:
  - rssi* hold their value.
  - inflight_real <= 0; the engine recomputes stale data as a dummy frame.
- rssi* change only at the edge following a commit window and stay stable for the entire busy interval.
- On out_valid:
  - If inflight_real: push {xt,yt} and increment frames_done.
  - Else: drop the result and increment frames_dummy.
  - The inflight_real evaluation uses the value before the same-cycle commit update.
- Result FIFO:
  - Push and pop may occur in the same cycle.
  - Push into a full FIFO is impossible by the credit rule; assertion-checked.
  - m_xt/m_yt are valid while m_valid is high; pop on m_valid && m_ready.
- LUT fetch FSM: IDLE -> RA -> RB -> RC -> IDLE.
  - IDLE: if {expA,expB,expC} != shadow, latch shadow, set lut_addr=expA, go to RA.
  - RA: lut_addr=expB_shadow, go to RB.
  - RB: valueA <= lut_rdata, lut_addr=expC_shadow, go to RC.
  - RC: valueB <= lut_rdata, go to IDLE.
  - IDLE after RC: valueC <= lut_rdata.
  - All values are updated within 5 cycles of an exp change.
  - An exp change during a fetch is caught on return to IDLE and refetched.
- Counters saturate at all-ones.
- Reset mid-frame: all state clears. The engine also resets, and the next frame is the engine's first (anchors re-sampled).

Decomposition:
- Shared package rfile_pkg holds:
  - Width constants: COORD_W=8, RSSI_W=20, EXP_W=12, VAL_W=16.
  - LUT FSM state enum.
- One natural sub-module: rfile_result_fifo (parameterised sync FIFO, count output).

Test Plan:
- Engine BFM (busy sequence matching the engine's frame timing), anchors A(0,0) B(100,0) C(0,100), s_valid held with one sample; BFM returns xt=30,yt=40 -> one FIFO entry (30,40), frames_done=1; subsequent frames counted as dummy, none pushed.
- No s_valid for 3 frames -> frames_dummy=3, m_valid stays 0, rssi* unchanged.
- m_ready=0, stream of 4 samples, FIFO_DEPTH=2 -> exactly 2 entries pushed, s_ready low in later commit windows, no overflow; raising m_ready drains the FIFO and resumes acceptance.
- Engine exp changes to A=0x000,B=0x800,C=0xFFF with ROM model -> lut_addr sequence 0x000,0x800,0xFFF and valueA/B/C updated within 5 cycles; an exp change mid-fetch triggers a refetch.
- Assert rst during a busy interval -> all outputs return to reset values at once; after release the first result is treated per inflight_real of the new first commit.
- Same-cycle push (out_valid) and pop with FIFO count 1 -> count stays 1, data order preserved.
